// File: rtl/sprite_ram_writer.sv
`default_nettype none
// ============================================================================
// Module      : sprite_ram_writer
// Description : Byte-serial producer for the 10-byte sprite attribute record.
//               Commands and data land in a shadow copy. The shadow is copied
//               into the active copy, one byte per cycle, after a vsync rise
//               while the shadow holds unpublished data. The renderer reads
//               the active copy through a combinational port.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_ram_writer (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       vsync,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       frame_done,
  output logic       err
);

  // Record geometry: addresses 0..9 (bytes 0-7 bitmap rows, 8 = X, 9 = Y)
  localparam int unsigned C_REC_BYTES = 10;
  localparam logic [3:0]  C_REC_SIZE  = 4'd10;
  localparam logic [3:0]  C_LAST_ADDR = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic       r_vsync_q;
  logic       r_dirty;
  logic       r_commit_req;
  logic [3:0] r_ptr;
  logic [3:0] r_cnt;
  logic [3:0] r_idx;
  logic       r_frame_done;
  logic       r_err;
  logic [7:0] r_shadow [0:C_REC_BYTES-1];
  logic [7:0] r_active [0:C_REC_BYTES-1];

  logic       w_vsync_rise;
  logic       w_cmd_ok;
  logic       w_cmd_bad;
  logic       w_data_wr;
  logic       w_commit_start;
  logic       w_commit_last;
  logic [3:0] w_ptr_inc;

  assign w_vsync_rise = vsync & ~r_vsync_q;
  assign w_ptr_inc    = (r_ptr == C_LAST_ADDR) ? 4'd0 : (r_ptr + 4'd1);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and handshake/status decode; a pending commit takes
  // precedence over a new command so the frame boundary is honoured promptly
  always_comb begin
    w_state_nxt    = r_state;
    in_ready       = 1'b0;
    busy           = 1'b0;
    w_cmd_ok       = 1'b0;
    w_cmd_bad      = 1'b0;
    w_data_wr      = 1'b0;
    w_commit_start = 1'b0;
    w_commit_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_commit_req) begin
          w_commit_start = 1'b1;
          w_state_nxt    = S_COMMIT;
        end else begin
          in_ready = 1'b1;
          if (in_valid) begin
            if (in_data[3:0] < C_REC_SIZE) begin
              w_cmd_ok    = 1'b1;
              w_state_nxt = S_DATA;
            end else begin
              w_cmd_bad = 1'b1;
            end
          end
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_data_wr = 1'b1;
          if (r_cnt == 4'd0) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_COMMIT: begin
        busy = 1'b1;
        if (r_idx == C_LAST_ADDR) begin
          w_commit_last = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Packet pointer and remaining-byte counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= 4'd0;
      r_cnt <= 4'd0;
    end else if (w_cmd_ok) begin
      r_ptr <= in_data[3:0];
      r_cnt <= in_data[7:4];
    end else if (w_data_wr) begin
      r_ptr <= w_ptr_inc;
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Commit index walks 0..9 while copying shadow into active
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx <= 4'd0;
    end else if (w_commit_start) begin
      r_idx <= 4'd0;
    end else if (r_state == S_COMMIT) begin
      r_idx <= r_idx + 4'd1;
    end
  end

  // vsync edge detector register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vsync_q <= 1'b0;
    end else begin
      r_vsync_q <= vsync;
    end
  end

  // Dirty and commit-request flags; entering COMMIT consumes both, since the
  // copy about to run publishes everything the shadow holds
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dirty      <= 1'b0;
      r_commit_req <= 1'b0;
    end else if (w_commit_start) begin
      r_dirty      <= 1'b0;
      r_commit_req <= 1'b0;
    end else begin
      if (w_vsync_rise && r_dirty) begin
        r_commit_req <= 1'b1;
      end
      if (w_data_wr) begin
        r_dirty <= 1'b1;
      end
    end
  end

  // Shadow copy: written by data bytes, visible after the accepting edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < C_REC_BYTES; i++) begin
        r_shadow[i] <= 8'h00;
      end
    end else if (w_data_wr) begin
      r_shadow[r_ptr] <= in_data;
    end
  end

  // Active copy: updated only during COMMIT, one byte per cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < C_REC_BYTES; i++) begin
        r_active[i] <= 8'h00;
      end
    end else if (r_state == S_COMMIT) begin
      r_active[r_idx] <= r_shadow[r_idx];
    end
  end

  // Single-cycle status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_frame_done <= w_commit_last;
      r_err        <= w_cmd_bad;
    end
  end

  assign frame_done = r_frame_done;
  assign err        = r_err;

  // Renderer read port: out-of-record addresses read as zero
  always_comb begin
    rd_data = 8'h00;
    if (rd_addr < C_REC_SIZE) begin
      rd_data = r_active[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_ram_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_ram_writer
// Description : Directed self-checking bench for sprite_ram_writer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_ram_writer;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       vsync;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic       frame_done;
  logic       err;

  int checks;
  int errors;
  logic [7:0] exp_mem [0:15];

  sprite_ram_writer dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .vsync      (vsync),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Advance to 5 time units after the next rising edge
  task automatic tick();
    @(posedge clk);
    #5;
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Present one byte and hold it until accepted; returns cycles spent waiting
  task automatic send_byte(input logic [7:0] b, output int waits);
    in_data  = b;
    in_valid = 1'b1;
    waits    = 0;
    while (!in_ready && waits < 40) begin
      tick();
      waits++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: byte %02h not accepted, in_ready=%b required 1", b, in_ready);
    end else begin
      tick();
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  // Wait for a commit to start, then count its busy cycles
  task automatic wait_commit(output int nbusy, output logic fd);
    nbusy = 0;
    for (int i = 0; i < 5 && !busy; i++) tick();
    while (busy && nbusy < 20) begin
      nbusy++;
      tick();
    end
    fd = frame_done;
  endtask

  task automatic do_commit(output int nbusy, output logic fd);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    wait_commit(nbusy, fd);
  endtask

  task automatic test_reset();
    int w;
    int nb;
    logic fd;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b busy=%b fd=%b err=%b required 1 0 0 0", in_ready, busy, frame_done, err);
    end
    // Publish a byte so the later reset has something to clear
    send_byte(8'h00, w);
    send_byte(8'h55, w);
    do_commit(nb, fd);
    rd_addr = 4'd0;
    #1;
    checks++;
    if (rd_data !== 8'h55) begin
      errors++;
      $display("FAIL reset_precommit: rd_data[0]=%02h required 55", rd_data);
    end
    // Reset asynchronously with a packet in flight and vsync rising
    send_byte(8'h31, w);
    send_byte(8'h77, w);
    in_valid = 1'b1;
    in_data  = 8'h66;
    vsync    = 1'b1;
    #10;
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_traffic: ready=%b busy=%b required 1 0", in_ready, busy);
    end
    for (int a = 0; a < 16; a++) begin
      rd_addr = a[3:0];
      #1;
      checks++;
      if (rd_data !== 8'h00) begin
        errors++;
        $display("FAIL reset_rd addr %0d: got %02h required 00", a, rd_data);
      end
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    vsync    = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    int w;
    int nb;
    logic fd;
    apply_reset();
    send_byte(8'h08, w);
    send_byte(8'h40, w);
    tick();
    tick();
    rd_addr = 4'd8;
    #1;
    checks++;
    if (rd_data !== 8'h00) begin
      errors++;
      $display("FAIL single_before_vsync: rd_data[8]=%02h required 00", rd_data);
    end
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_pending: busy=%b ready=%b required 0 0", busy, in_ready);
    end
    wait_commit(nb, fd);
    checks++;
    if (nb !== 10 || fd !== 1'b1) begin
      errors++;
      $display("FAIL single_commit: busy_cycles=%0d fd=%b required 10 1", nb, fd);
    end
    tick();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL single_fd_pulse: frame_done=%b required 0", frame_done);
    end
    for (int a = 0; a < 16; a++) exp_mem[a] = 8'h00;
    exp_mem[8] = 8'h40;
    for (int a = 0; a < 16; a++) begin
      rd_addr = a[3:0];
      #1;
      checks++;
      if (rd_data !== exp_mem[a]) begin
        errors++;
        $display("FAIL single_rd addr %0d: got %02h required %02h", a, rd_data, exp_mem[a]);
      end
    end
  endtask

  task automatic test_burst_wrap();
    int w;
    int nb;
    logic fd;
    apply_reset();
    send_byte(8'hB8, w);
    for (int i = 1; i <= 12; i++) send_byte(i[7:0], w);
    do_commit(nb, fd);
    checks++;
    if (nb !== 10 || fd !== 1'b1) begin
      errors++;
      $display("FAIL burst_commit: busy_cycles=%0d fd=%b required 10 1", nb, fd);
    end
    for (int a = 0; a < 8; a++) exp_mem[a] = 8'(a + 3);
    exp_mem[8] = 8'h0B;
    exp_mem[9] = 8'h0C;
    for (int a = 0; a < 10; a++) begin
      rd_addr = a[3:0];
      #1;
      checks++;
      if (rd_data !== exp_mem[a]) begin
        errors++;
        $display("FAIL burst_rd addr %0d: got %02h required %02h", a, rd_data, exp_mem[a]);
      end
    end
  endtask

  task automatic test_reject();
    int w;
    int nb;
    logic fd;
    apply_reset();
    send_byte(8'h0A, w);
    checks++;
    if (err !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reject_pulse: err=%b ready=%b required 1 1", err, in_ready);
    end
    tick();
    checks++;
    if (err !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reject_single: err=%b ready=%b required 0 1", err, in_ready);
    end
    send_byte(8'hFF, w);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL reject_addr15: err=%b required 1", err);
    end
    send_byte(8'h09, w);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL reject_addr9_ok: err=%b required 0", err);
    end
    send_byte(8'h22, w);
    do_commit(nb, fd);
    rd_addr = 4'd9;
    #1;
    checks++;
    if (rd_data !== 8'h22 || fd !== 1'b1) begin
      errors++;
      $display("FAIL reject_follow: rd_data[9]=%02h fd=%b required 22 1", rd_data, fd);
    end
    rd_addr = 4'd8;
    #1;
    checks++;
    if (rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reject_nodata: rd_data[8]=%02h required 00", rd_data);
    end
  endtask

  task automatic test_vsync_mid_packet();
    int w;
    int nb;
    logic fd;
    apply_reset();
    send_byte(8'h20, w);
    send_byte(8'hA1, w);
    vsync = 1'b1;
    send_byte(8'hA2, w);
    vsync = 1'b0;
    send_byte(8'hA3, w);
    checks++;
    if (w !== 0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_packet_hold: waits=%0d ready=%b required 0 0", w, in_ready);
    end
    wait_commit(nb, fd);
    checks++;
    if (nb !== 10 || fd !== 1'b1) begin
      errors++;
      $display("FAIL mid_packet_commit: busy_cycles=%0d fd=%b required 10 1", nb, fd);
    end
    for (int a = 0; a < 10; a++) exp_mem[a] = 8'h00;
    exp_mem[0] = 8'hA1;
    exp_mem[1] = 8'hA2;
    exp_mem[2] = 8'hA3;
    for (int a = 0; a < 10; a++) begin
      rd_addr = a[3:0];
      #1;
      checks++;
      if (rd_data !== exp_mem[a]) begin
        errors++;
        $display("FAIL mid_packet_rd addr %0d: got %02h required %02h", a, rd_data, exp_mem[a]);
      end
    end
  endtask

  task automatic test_nodirty_and_reset_commit();
    int w;
    int saw_busy;
    int saw_fd;
    // vsync held high across reset release: counts as a rise with dirty=0
    vsync = 1'b1;
    apply_reset();
    saw_busy = 0;
    saw_fd   = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy) saw_busy++;
      if (frame_done) saw_fd++;
      tick();
    end
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (busy) saw_busy++;
      if (frame_done) saw_fd++;
      tick();
    end
    vsync = 1'b0;
    checks++;
    if (saw_busy !== 0 || saw_fd !== 0) begin
      errors++;
      $display("FAIL nodirty_vsync: busy_cycles=%0d fd_cycles=%0d required 0 0", saw_busy, saw_fd);
    end
    send_byte(8'h00, w);
    send_byte(8'hFF, w);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
    // Now in commit cycle 1 (idx 0); advance to commit cycle 4
    tick();
    tick();
    tick();
    rd_addr = 4'd0;
    #1;
    checks++;
    if (busy !== 1'b1 || rd_data !== 8'hFF) begin
      errors++;
      $display("FAIL partial_commit: busy=%b rd_data[0]=%02h required 1 FF", busy, rd_data);
    end
    reset = 1'b1;
    #1;
    for (int a = 0; a < 10; a++) begin
      rd_addr = a[3:0];
      #1;
      checks++;
      if (rd_data !== 8'h00) begin
        errors++;
        $display("FAIL reset_commit_rd addr %0d: got %02h required 00", a, rd_data);
      end
    end
    tick();
    reset  = 1'b0;
    saw_fd = 0;
    saw_busy = 0;
    for (int i = 0; i < 15; i++) begin
      if (frame_done) saw_fd++;
      if (busy) saw_busy++;
      tick();
    end
    checks++;
    if (saw_fd !== 0 || saw_busy !== 0) begin
      errors++;
      $display("FAIL reset_commit_fd: fd_cycles=%0d busy_cycles=%0d required 0 0", saw_fd, saw_busy);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;
    vsync    = 1'b0;
    rd_addr  = 4'd0;
    apply_reset();
    test_reset();
    test_single_write();
    test_burst_wrap();
    test_reject();
    test_vsync_mid_packet();
    test_nodirty_and_reset_commit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sprite_ram_writer.md
# sprite_ram_writer

Producer side of the sprite attribute RAM: accepts a byte-serial command stream from the CPU/loader and writes the 10-byte sprite record (bytes 0–7 bitmap rows, byte 8 X, byte 9 Y) into a shadow copy. The shadow is committed to the active copy only at the start of vertical blank, so the sprite renderer never sees a half-updated sprite. The renderer reads the active copy through a combinational read port.

## Interface
- No parameters. Record size is fixed at 10 bytes, address 0–9.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_data  in  8  command/data byte
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts a byte this cycle
- vsync  in  1  vertical sync level from the video timing generator
- rd_addr  in  4  renderer read address (0–9)
- rd_data  out  8  active RAM byte at rd_addr; 0 for rd_addr ≥ 10
- busy  out  1  commit in progress
- frame_done  out  1  one-cycle pulse when a commit completes
- err  out  1  one-cycle pulse when a command is rejected

## Operation
- Byte transfer: occurs on a rising clk edge with in_valid & in_ready. in_data must be held while in_valid=1 and in_ready=0.
- Command byte: bits[3:0] = start address A, bits[7:4] = length-1, giving N = 1..16 data bytes.
- A ≥ 10: command rejected. err pulses, the block stays in IDLE, and no data phase follows.
- Data bytes are written to shadow[ptr], starting at ptr=A.
  - ptr increments and wraps 9→0, so N > 10 overwrites earlier bytes in the same packet.
  - Each data byte sets the dirty flag.
- vsync rise: detected as vsync & ~vsync_q, where vsync_q is a registered copy of vsync. A rise with dirty=1 sets commit_req. A rise with dirty=0 does nothing.
- States:
  - IDLE: in_ready=1. If commit_req=1, go to COMMIT (in_ready=0 in that cycle, no byte accepted) and clear commit_req and dirty. Otherwise an accepted valid command goes to DATA, loading ptr=A and cnt=N-1.
  - DATA: in_ready=1. Each accepted byte writes the shadow. After the byte with cnt=0, return to IDLE.
    - A vsync rise during DATA only latches commit_req. The commit waits until the packet completes.
  - COMMIT: in_ready=0, busy=1. idx steps 0..9, copying active[idx] ← shadow[idx], one byte per cycle. After idx=9, go to IDLE with frame_done=1 for one cycle.
    - A vsync rise during COMMIT is ignored unless dirty was set again; bytes cannot be accepted in COMMIT, so dirty stays 0.
- Reset values:
  - State IDLE, in_ready=1, busy=0, frame_done=0, err=0.
  - commit_req=0, dirty=0, vsync_q=0.
  - Shadow and active arrays all 0x00, so rd_data=0.
- Reset mid-packet or mid-commit: everything returns to reset values immediately. A partial commit is discarded, since active is cleared.
- If vsync is high when reset releases, the first cycle counts as a rise. Because dirty=0 after reset, this has no effect.

## Timing
- Shadow write latency: the byte is visible in shadow after the accepting edge.
- Commit start: the rise is sampled at edge t, setting commit_req. COMMIT is entered at t+1 if the state is IDLE.
- Commit duration: active[k] updates at edge t+2+k for k=0..9. frame_done is high in the cycle after active[9] is written.
- From the vsync rise edge to all 10 bytes active: 11 cycles.
- rd_data: combinational from active, with zero latency.
- err: high for the single cycle after the rejecting edge.

## Test plan
- Reset check: assert reset with traffic present. Required: in_ready=1, busy=0, and rd_data=0 for all addresses 0–9.
- Single write and commit: send cmd 0x08, data 0x40 (X=0x40). Required: rd_data[8] stays 0 until a vsync rise. After the rise, busy=1 for 10 cycles, then frame_done pulses and rd_data[8]=0x40.
- Burst with wrap-around: send cmd 0xB8 (A=8, N=12) with data 0x01..0x0C, then a vsync rise. Required after commit: active[8]=0x0B, active[9]=0x0C, active[0..7]=0x03..0x0A.
- Reject: send cmd 0x0A. Required: err pulses once and in_ready stays 1. A following cmd 0x09 with data 0x22 is accepted normally and gives active[9]=0x22 after vsync.
- vsync mid-packet: send cmd 0x20 (N=3), send 1 byte, raise vsync, then send the remaining 2 bytes. Required: COMMIT starts the cycle after the 3rd byte is accepted, and all 3 bytes appear in active.
- No-dirty vsync, then reset mid-commit:
  - A vsync rise with dirty=0 gives no busy and no frame_done.
  - Then write byte 0 = 0xFF, raise vsync, and assert reset at commit cycle 4. Required: all active bytes are 0 and frame_done never pulses.
